// File: rtl/key_event_fifo_pkg.sv
// key_event_fifo_pkg: shared keyboard CPLD constants, FIFO op encoding and clear-command decode
package key_event_fifo_pkg;
  localparam int FIFO_EVENT_WIDTH = 8;
  localparam int FIFO_DEPTH_LOG2 = 4;
  localparam logic [FIFO_EVENT_WIDTH-1:0] FIFO_EMPTY_CODE = 8'h00;
  localparam logic [7:0] CMD_ADDR_FIFO_CLR = 8'd1;
  localparam logic [7:0] CMD_DATA_FIFO_CLR = 8'd0;
  typedef enum logic [2:0] {
    OP_IDLE,
    OP_PUSH,
    OP_POP,
    OP_BOTH,
    OP_DROP,
    OP_CLR
  } fifo_op_e;
  function automatic logic is_fifo_clr(input logic wr, input logic [7:0] addr, input logic [7:0] data);
    return wr && addr == CMD_ADDR_FIFO_CLR && data == CMD_DATA_FIFO_CLR;
  endfunction
endpackage

// File: rtl/key_event_fifo_edge_pulse.sv
// edge_pulse: one-cycle pulse on each rising edge of a same-domain level
module edge_pulse (
  input  logic clk,
  input  logic rst,
  input  logic in,
  output logic pulse
);
  logic in_q, in_d;
  // history is the level seen at the previous edge, updated every cycle
  always_comb in_d = in;
  // history register
  always_ff @(posedge clk) in_q <= rst ? 1'b0 : in_d;
  assign pulse = in & ~in_q;
endmodule

// File: rtl/key_event_fifo.sv
// key_event_fifo: first-word-fall-through event queue between keyboard scanner and SPI reply path
module key_event_fifo
  import key_event_fifo_pkg::*;
#(
  parameter int DATA_W = FIFO_EVENT_WIDTH,
  parameter int DEPTH_LOG2 = FIFO_DEPTH_LOG2,
  parameter logic [DATA_W-1:0] EMPTY_CODE = DATA_W'(FIFO_EMPTY_CODE)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  evReady,
  input  logic [DATA_W-1:0]     evCode,
  input  logic                  rdEn,
  input  logic                  clr,
  output logic [DATA_W-1:0]     outData,
  output logic                  empty,
  output logic                  full,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  overflow
);
  localparam int CW = DEPTH_LOG2 + 1;
  localparam logic [CW-1:0] DEPTH = CW'(1 << DEPTH_LOG2);
  localparam logic [CW-1:0] ONE = CW'(1);
  logic wr_pulse, rd_pulse, push, pop;
  fifo_op_e op;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic overflow_q, overflow_d;
  edge_pulse u_wr_edge (.clk(clk), .rst(rst), .in(evReady), .pulse(wr_pulse));
  edge_pulse u_rd_edge (.clk(clk), .rst(rst), .in(rdEn), .pulse(rd_pulse));
  assign empty = count_q == '0;
  assign full = count_q == DEPTH;
  assign count = count_q;
  assign overflow = overflow_q;
  assign outData = empty ? EMPTY_CODE : mem_q[rd_ptr_q];
  // classify this edge: clear wins, a pop frees the slot a full push needs, a pop on empty is ignored
  always_comb begin
    op = OP_IDLE;
    op = clr ? OP_CLR
       : (wr_pulse && rd_pulse && !empty) ? OP_BOTH
       : (wr_pulse && !full) ? OP_PUSH
       : wr_pulse ? OP_DROP
       : (rd_pulse && !empty) ? OP_POP
       : OP_IDLE;
    push = op == OP_PUSH || op == OP_BOTH;
    pop = op == OP_POP || op == OP_BOTH;
  end
  // pointer, fill level and sticky overflow next state
  always_comb begin
    wr_ptr_d = op == OP_CLR ? '0 : wr_ptr_q + DEPTH_LOG2'(push);
    rd_ptr_d = op == OP_CLR ? '0 : rd_ptr_q + DEPTH_LOG2'(pop);
    count_d = op == OP_CLR ? '0
            : op == OP_PUSH ? count_q + ONE
            : op == OP_POP ? count_q - ONE
            : count_q;
    overflow_d = op != OP_CLR && (overflow_q || op == OP_DROP);
  end
  // control state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q <= count_d;
      overflow_q <= overflow_d;
    end
  end
  // storage array, not reset; on full push+pop the written slot is the one being vacated
  always_ff @(posedge clk) begin
    if (!rst && push) mem_q[wr_ptr_q] <= evCode;
  end
endmodule

// File: tb/tb_key_event_fifo.sv
// tb_key_event_fifo: directed self-checking bench for key_event_fifo
module tb_key_event_fifo;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic evReady = 1'b0;
  logic [7:0] evCode = 8'h00;
  logic rdEn = 1'b0;
  logic clr = 1'b0;
  logic [7:0] outData;
  logic empty, full, overflow;
  logic [4:0] count;
  int errs = 0;
  int checks = 0;
  key_event_fifo dut (
    .clk(clk), .rst(rst), .evReady(evReady), .evCode(evCode), .rdEn(rdEn),
    .clr(clr), .outData(outData), .empty(empty), .full(full), .count(count),
    .overflow(overflow)
  );
  always #5 clk = ~clk;
  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic push(input logic [7:0] code, input int hold = 1);
    evCode = code;
    evReady = 1'b1;
    step(hold);
    evReady = 1'b0;
    step();
  endtask
  task automatic pop();
    rdEn = 1'b1;
    step();
    rdEn = 1'b0;
    step();
  endtask
  initial begin
    step(2);
    rst = 1'b0;
    chk("rst_empty", 32'(empty), 1);
    chk("rst_full", 32'(full), 0);
    chk("rst_count", 32'(count), 0);
    chk("rst_out", 32'(outData), 32'h00);
    chk("rst_ovf", 32'(overflow), 0);
    push(8'h11, 3);
    push(8'h22, 3);
    push(8'h33, 3);
    chk("t1_count", 32'(count), 3);
    chk("t1_out0", 32'(outData), 32'h11);
    pop();
    chk("t1_out1", 32'(outData), 32'h22);
    pop();
    chk("t1_out2", 32'(outData), 32'h33);
    pop();
    chk("t1_out3", 32'(outData), 32'h00);
    chk("t1_empty", 32'(empty), 1);
    for (int i = 1; i <= 16; i++) push(8'(i));
    chk("t2_full", 32'(full), 1);
    chk("t2_count16", 32'(count), 16);
    chk("t2_ovf_pre", 32'(overflow), 0);
    push(8'h11);
    chk("t2_ovf", 32'(overflow), 1);
    chk("t2_count_drop", 32'(count), 16);
    for (int i = 1; i <= 16; i++) begin
      chk($sformatf("t2_drain%0d", i), 32'(outData), 32'(i));
      pop();
    end
    chk("t2_out_empty", 32'(outData), 32'h00);
    chk("t2_empty", 32'(empty), 1);
    chk("t2_ovf_sticky", 32'(overflow), 1);
    clr = 1'b1;
    step();
    clr = 1'b0;
    step();
    chk("t3_ovf_clr", 32'(overflow), 0);
    for (int i = 0; i < 16; i++) push(8'hA0 + 8'(i));
    evCode = 8'h55;
    evReady = 1'b1;
    rdEn = 1'b1;
    step();
    evReady = 1'b0;
    rdEn = 1'b0;
    step();
    chk("t3_count", 32'(count), 16);
    chk("t3_ovf", 32'(overflow), 0);
    chk("t3_full", 32'(full), 1);
    for (int i = 1; i < 16; i++) begin
      chk($sformatf("t3_drain%0d", i), 32'(outData), 32'h A0 + 32'(i));
      pop();
    end
    chk("t3_last", 32'(outData), 32'h55);
    pop();
    chk("t3_empty", 32'(empty), 1);
    evCode = 8'h42;
    evReady = 1'b1;
    rdEn = 1'b1;
    step();
    chk("t4_count", 32'(count), 1);
    chk("t4_out", 32'(outData), 32'h42);
    evReady = 1'b0;
    rdEn = 1'b0;
    step();
    pop();
    chk("t4_empty", 32'(empty), 1);
    for (int i = 0; i < 17; i++) push(8'hB0 + 8'(i));
    for (int i = 0; i < 11; i++) pop();
    chk("t5_count5", 32'(count), 5);
    chk("t5_ovf_set", 32'(overflow), 1);
    chk("t5_out", 32'(outData), 32'hBB);
    evCode = 8'h99;
    evReady = 1'b1;
    clr = 1'b1;
    step();
    clr = 1'b0;
    chk("t5_clr_count", 32'(count), 0);
    chk("t5_clr_empty", 32'(empty), 1);
    chk("t5_clr_ovf", 32'(overflow), 0);
    step();
    chk("t5_held_no_push", 32'(count), 0);
    evReady = 1'b0;
    step();
    push(8'h5A);
    chk("t5_post_count", 32'(count), 1);
    chk("t5_post_out", 32'(outData), 32'h5A);
    push(8'h61);
    push(8'h62);
    push(8'h63);
    chk("t6_count4", 32'(count), 4);
    rdEn = 1'b1;
    step(10);
    chk("t6_one_pop", 32'(count), 3);
    chk("t6_out", 32'(outData), 32'h61);
    rst = 1'b1;
    step();
    chk("t6_rst_empty", 32'(empty), 1);
    chk("t6_rst_full", 32'(full), 0);
    chk("t6_rst_count", 32'(count), 0);
    chk("t6_rst_out", 32'(outData), 32'h00);
    chk("t6_rst_ovf", 32'(overflow), 0);
    rst = 1'b0;
    rdEn = 1'b0;
    step();
    chk("t6_post_rst", 32'(count), 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
